// File: rtl/seg_disp_arbiter.sv
// Round-robin arbiter sharing one multiplexed 4-digit seven-segment display among three requesters.
// Optional leading-zero blanking when SEG_DISP_ARBITER_LZB_EN is defined.
module seg_disp_arbiter #(
  parameter int SCAN_DIV   = 8333,
  parameter int HOLD_SCANS = 240
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [2:0]  req,
  input  logic [15:0] val0,
  input  logic [15:0] val1,
  input  logic [15:0] val2,
  output logic [2:0]  gnt,
  output logic [3:0]  anodes,
  output logic [3:0]  hex_cur,
  output logic        tick
);

  localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [11:0]   HOLD_MAX   = 12'(HOLD_SCANS);

  typedef enum logic {IDLE, OWN} state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] presc;
  logic [1:0]    scan_idx, scan_nxt;
  logic [11:0]   hold_cnt, hold_nxt;
  logic [1:0]    last_owner, owner_nxt;
  logic [2:0]    gnt_nxt;
  logic [15:0]   gval_p0;
  logic [3:0]    digit_p0;
  logic          blank_p0;

  // First requester after 'from' in the cyclic order from+1, from+2, from.
  function automatic logic [1:0] rr_pick(input logic [1:0] from, input logic [2:0] r);
    logic [1:0] a;
    logic [1:0] b;
    a = (from == 2'd2) ? 2'd0 : from + 2'd1;
    b = (a == 2'd2) ? 2'd0 : a + 2'd1;
    if (r[a])      return a;
    else if (r[b]) return b;
    else           return from;
  endfunction

  assign tick     = (presc == PRESC_LAST);
  assign scan_nxt = scan_idx + 2'd1;

  always_comb begin
    gval_p0 = 16'h0000;
    case (gnt)
      3'b001:  gval_p0 = val0;
      3'b010:  gval_p0 = val1;
      3'b100:  gval_p0 = val2;
      default: gval_p0 = 16'h0000;
    endcase
  end

  always_comb begin
    digit_p0 = 4'h0;
    case (scan_nxt)
      2'd0: digit_p0 = gval_p0[3:0];
      2'd1: digit_p0 = gval_p0[7:4];
      2'd2: digit_p0 = gval_p0[11:8];
      2'd3: digit_p0 = gval_p0[15:12];
      default: digit_p0 = 4'h0;
    endcase
  end

`ifdef SEG_DISP_ARBITER_LZB_EN
  // A digit is blanked when it and every more significant digit are zero.
  always_comb begin
    blank_p0 = 1'b0;
    case (scan_nxt)
      2'd1: blank_p0 = (gval_p0[15:4] == 12'h000);
      2'd2: blank_p0 = (gval_p0[15:8] == 8'h00);
      2'd3: blank_p0 = (gval_p0[15:12] == 4'h0);
      default: blank_p0 = 1'b0;
    endcase
  end
`else
  assign blank_p0 = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    owner_nxt = last_owner;
    gnt_nxt   = gnt;
    hold_nxt  = hold_cnt;
    case (state)
      IDLE: begin
        if (|req) begin
          state_nxt = OWN;
          owner_nxt = rr_pick(last_owner, req);
          gnt_nxt   = 3'b001 << owner_nxt;
          hold_nxt  = 12'd0;
        end
      end
      OWN: begin
        // While owning, last_owner is the current owner.
        if (!req[last_owner]) begin
          state_nxt = IDLE;
          gnt_nxt   = 3'b000;
        end else if ((hold_cnt == HOLD_MAX) && (|(req & ~gnt))) begin
          owner_nxt = rr_pick(last_owner, req);
          gnt_nxt   = 3'b001 << owner_nxt;
          hold_nxt  = 12'd0;
        end else if (tick && (hold_cnt != HOLD_MAX)) begin
          hold_nxt = hold_cnt + 12'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = 3'b000;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      gnt        <= 3'b000;
      last_owner <= 2'd2;
      hold_cnt   <= 12'd0;
    end else begin
      state      <= state_nxt;
      gnt        <= gnt_nxt;
      last_owner <= owner_nxt;
      hold_cnt   <= hold_nxt;
    end
  end

  // Scan stage: outputs refresh on the tick clk with the advanced index.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc    <= '0;
      scan_idx <= 2'd0;
      anodes   <= 4'hF;
      hex_cur  <= 4'h0;
    end else begin
      presc <= tick ? '0 : presc + PW'(1);
      if (tick) begin
        scan_idx <= scan_nxt;
        anodes   <= (en && (state == OWN) && !blank_p0) ? ~(4'b0001 << scan_nxt) : 4'hF;
        hex_cur  <= digit_p0;
      end
    end
  end

endmodule

// File: doc/seg_disp_arbiter.md
SEG_DISP_ARBITER -- requirements
Module: seg_disp_arbiter

Interface
REQ-001 Parameter SCAN_DIV, default 8333: clk cycles per digit-scan tick; legal range 2..2^20.
REQ-002 Parameter HOLD_SCANS, default 240: minimum scan ticks an owner keeps the display before preemption; legal range 1..4095.
REQ-003 clk  input  1  system clock; all logic on posedge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 en  input  1  display enable, active high.
REQ-006 req  input  3  per-requester display request, bit i = requester i.
REQ-007 val0, val1, val2  input  16 each  four hex digits per requester; [3:0] is the rightmost digit.
REQ-008 gnt  output  3  one-hot grant, all zero when idle; registered.
REQ-009 anodes  output  4  digit enables, active low; registered.
REQ-010 hex_cur  output  4  nibble for the currently enabled digit, feeding the existing hex-to-segment decoder; registered.
REQ-011 tick  output  1  one-clk pulse per scan tick.

Function
REQ-012 Prescaler: a counter runs 0..SCAN_DIV-1 and wraps; tick is high for one clk when the counter equals SCAN_DIV-1.
REQ-013 Scan index: 2-bit, increments on tick, wraps 3->0.
REQ-014 Anode and digit map: index 0 -> anodes 4'b1110 with val[3:0]; 1 -> 4'b1101 with [7:4]; 2 -> 4'b1011 with [11:8]; 3 -> 4'b0111 with [15:12].
REQ-015 anodes and hex_cur update only on the clk where tick is high, using the post-increment index and the granted value sampled that clk (one-clk latency from tick).
REQ-016 anodes is 4'hF whenever en=0 or state=IDLE at the update; arbitration and scan keep running regardless of en.
REQ-017 FSM states: IDLE, OWN.
REQ-018 IDLE: if req is nonzero, next clk enter OWN, grant the first requesting index after last_owner in round-robin order (last_owner+1, +2, +3 mod 3), and clear hold_cnt.
REQ-019 OWN, owner's req bit low: next clk go to IDLE with gnt=0; this takes precedence over every other OWN rule.
REQ-020 OWN: hold_cnt (12-bit) increments on tick and saturates at HOLD_SCANS.
REQ-021 OWN with hold_cnt=HOLD_SCANS and another req bit high: next clk grant the next requester in round-robin order after the current owner, and clear hold_cnt.
REQ-022 OWN with only the owner requesting: keep the grant indefinitely.
REQ-023 last_owner updates to the granted index whenever a grant is issued.
REQ-024 Grant changes do not reset the prescaler or the scan index.

Reset
REQ-025 While rst=1 at posedge: state=IDLE, gnt=3'b000, anodes=4'hF, hex_cur=4'h0, tick=0, prescaler=0, scan index=0, hold_cnt=0, last_owner=2 (requester 0 is first priority).
REQ-026 Reset mid-ownership drops the grant in the same cycle; after reset, arbitration restarts per REQ-018.

Configuration
REQ-027 Macro SEG_DISP_ARBITER_LZB_EN, when defined, enables leading-zero blanking: a digit at index k in 1..3 is blanked (anodes 4'hF for that scan slot) when it and all digits above it are zero; digit 0 is never blanked.
REQ-028 Without SEG_DISP_ARBITER_LZB_EN, all four digits always display; no blanking logic is synthesized.

Verification (SCAN_DIV=4, HOLD_SCANS=3)
REQ-029 Release rst, hold req=000 for 40 clk -> gnt=000 throughout; anodes=4'hF throughout; tick pulses every 4th clk.
REQ-030 req=001, val0=16'h1234, en=1 -> gnt=001 one clk later; anodes cycles 1101,1011,0111,1110 with hex_cur 3,2,1,4, each held 4 clk.
REQ-031 Requester 0 owns, req rises to 011 -> gnt stays 001 until 3 ticks have counted, then becomes 010 one clk later; with req held at 011, ownership alternates 0,1 every 3 ticks.
REQ-032 Owner 1 drops req while req[2]=1 -> one clk with gnt=000, then gnt=100.
REQ-033 en=0 during ownership -> anodes=4'hF at the next tick, gnt unchanged; assert rst mid-ownership -> gnt=000 and all REQ-025 values at the next clk.
REQ-034 With SEG_DISP_ARBITER_LZB_EN defined, val0=16'h0050 -> only anodes 1110 (hex_cur 0) and 1101 (hex_cur 5) go active; without the macro, all four anodes go active.
